// File: rtl/sdma_sink_if.sv
// Handshake bundle between sdma_sink, the SDMA channel and the downstream consumer.
// The slave modport is the sink's view; master is the environment driving it.
interface sdma_sink_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  sdma_req;
    logic                  sdma_active;
    logic                  sdma_done;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (
        input  sdma_req, data, valid,
        output sdma_active, sdma_done, wr_data, wr_en, ready
    );

    modport slave (
        output sdma_req, data, valid,
        input  sdma_active, sdma_done, wr_data, wr_en, ready
    );
endinterface

// File: rtl/sdma_sink.sv
// Fabric-side SDMA receiver: requests bursts while the FIFO has room, presents words as a FWFT stream.
// Define SDMA_SINK_IRQ_EN to build the one-cycle sdma_irq completion pulse; otherwise sdma_irq is tied low.
module sdma_sink #(
    parameter int DST_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int BURST_LEN      = 4
) (
    input  logic        clk,
    input  logic        rst,
    sdma_sink_if.slave  bus,
    output logic        sdma_irq,
    output logic        overflow
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } state_t;

    logic [DST_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      overflow_q, overflow_d;
    state_t                    state_q, state_d;
    logic                      req_q, req_d;
    logic                      push;
    logic                      pop;

    // Full check uses the registered count only, so a pop cannot make room for a same-cycle write.
    assign push = bus.wr_en && (count_q < DEPTH_C);
    assign pop  = (count_q != '0) && bus.ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.wr_en & ~push);
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((DEPTH_C - count_q) >= BURST_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.sdma_active) begin
                    state_d = XFER;
                end else if (bus.sdma_done) begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (bus.sdma_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: valid masks whatever the array holds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef SDMA_SINK_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = ((state_q == REQ) && !bus.sdma_active && bus.sdma_done) ||
                   ((state_q == XFER) && bus.sdma_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign sdma_irq = irq_q;
`else
    assign sdma_irq = 1'b0;
`endif

    assign bus.sdma_req = req_q;
    assign bus.valid    = (count_q != '0);
    assign bus.data     = mem_q[rd_ptr_q];
    assign overflow     = overflow_q;
endmodule
